md_unit: RTL and testbench

Iterative multiply/divide unit for the E stage of the five-stage MIPS pipeline. It executes MULT/MULTU/DIV/DIVU over a fixed number of cycles, holds the HI/LO architectural registers, and services MTHI/MTLO writes and MFHI/MFLO reads. Its `busy` output feeds the hazard/forwarding unit. That unit stalls D and flushes E whenever an HI/LO-touching instruction sits in D while `start | busy` is high.

---
 rtl/md_unit.sv | 159 +++++++++++++++
 tb/tb_md_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : md_unit
//  Description : Iterative MIPS multiply/divide unit holding HI/LO; fixed
//                latency MULT/MULTU/DIV/DIVU plus zero-latency MTHI/MTLO.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int c_MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int c_CNT_W   = ($clog2(c_MAX_CYC + 1) > 4) ? $clog2(c_MAX_CYC + 1) : 4;

   localparam logic [c_CNT_W-1:0] c_MULT_N = c_CNT_W'(MULT_CYCLES);
   localparam logic [c_CNT_W-1:0] c_DIV_N  = c_CNT_W'(DIV_CYCLES);
   localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);

   localparam logic [2:0] c_OP_MULT  = 3'd0;
   localparam logic [2:0] c_OP_MULTU = 3'd1;
   localparam logic [2:0] c_OP_DIV   = 3'd2;
   localparam logic [2:0] c_OP_DIVU  = 3'd3;
   localparam logic [2:0] c_OP_MTHI  = 3'd4;
   localparam logic [2:0] c_OP_MTLO  = 3'd5;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [31:0]        r_res_hi, w_res_hi_nxt;
   logic [31:0]        r_res_lo, w_res_lo_nxt;
   logic               r_res_wr, w_res_wr_nxt;
   logic [31:0]        r_hi, w_hi_nxt;
   logic [31:0]        r_lo, w_lo_nxt;

   // Arithmetic on the operands present at the start edge
   logic [63:0] w_a_ext, w_b_ext, w_prod_s, w_prod_u;
   logic        w_b_zero;
   logic [31:0] w_b_safe, w_a_mag, w_b_mag, w_qs_mag, w_rs_mag, w_qs, w_rs, w_qu, w_ru;

   assign w_a_ext  = {{32{A[31]}}, A};
   assign w_b_ext  = {{32{B[31]}}, B};
   assign w_prod_s = w_a_ext * w_b_ext;
   assign w_prod_u = {32'd0, A} * {32'd0, B};

   // Divisor forced non-zero so no divide-by-zero ever reaches the datapath
   assign w_b_zero = (B == 32'd0);
   assign w_b_safe = w_b_zero ? 32'd1 : B;
   assign w_a_mag  = A[31] ? -A : A;
   assign w_b_mag  = w_b_safe[31] ? -w_b_safe : w_b_safe;
   assign w_qs_mag = w_a_mag / w_b_mag;
   assign w_rs_mag = w_a_mag % w_b_mag;
   assign w_qs     = (A[31] ^ w_b_safe[31]) ? -w_qs_mag : w_qs_mag;
   assign w_rs     = A[31] ? -w_rs_mag : w_rs_mag;
   assign w_qu     = A / w_b_safe;
   assign w_ru     = A % w_b_safe;

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_res_hi_nxt = r_res_hi;
      w_res_lo_nxt = r_res_lo;
      w_res_wr_nxt = r_res_wr;
      w_hi_nxt     = r_hi;
      w_lo_nxt     = r_lo;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               case (md_op)
                  c_OP_MULT: begin
                     {w_res_hi_nxt, w_res_lo_nxt} = w_prod_s;
                     w_res_wr_nxt = 1'b1;
                     w_cnt_nxt    = c_MULT_N;
                     w_state_nxt  = S_RUN;
                  end
                  c_OP_MULTU: begin
                     {w_res_hi_nxt, w_res_lo_nxt} = w_prod_u;
                     w_res_wr_nxt = 1'b1;
                     w_cnt_nxt    = c_MULT_N;
                     w_state_nxt  = S_RUN;
                  end
                  c_OP_DIV: begin
                     w_res_hi_nxt = w_rs;
                     w_res_lo_nxt = w_qs;
                     w_res_wr_nxt = !w_b_zero;
                     w_cnt_nxt    = c_DIV_N;
                     w_state_nxt  = S_RUN;
                  end
                  c_OP_DIVU: begin
                     w_res_hi_nxt = w_ru;
                     w_res_lo_nxt = w_qu;
                     w_res_wr_nxt = !w_b_zero;
                     w_cnt_nxt    = c_DIV_N;
                     w_state_nxt  = S_RUN;
                  end
                  c_OP_MTHI: w_hi_nxt = A;
                  c_OP_MTLO: w_lo_nxt = A;
                  default: ;
               endcase
            end
         end
         S_RUN: begin
            // Completion edge: pending result lands in HI/LO as busy drops
            if (r_cnt == c_ONE) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
               if (r_res_wr) begin
                  w_hi_nxt = r_res_hi;
                  w_lo_nxt = r_res_lo;
               end
            end else begin
               w_cnt_nxt = r_cnt - c_ONE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_res_hi <= '0;
         r_res_lo <= '0;
         r_res_wr <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_res_hi <= w_res_hi_nxt;
         r_res_lo <= w_res_lo_nxt;
         r_res_wr <= w_res_wr_nxt;
         r_hi     <= w_hi_nxt;
         r_lo     <= w_lo_nxt;
      end
   end

   assign busy = (r_state == S_RUN);
   assign HI   = r_hi;
   assign LO   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_md_unit
//  Description : Scoreboard bench for md_unit with a behavioural HI/LO model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_md_unit;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [2:0]  md_op;
   logic [31:0] A, B;
   logic        busy;
   logic [31:0] HI, LO;

   always #5 clk = ~clk;

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .md_op (md_op),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .HI    (HI),
      .LO    (LO)
   );

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          n;
   } exp_t;

   exp_t        sb_q[$];
   int          total = 0;
   int          bad   = 0;
   logic [31:0] hi_m  = 32'd0;
   logic [31:0] lo_m  = 32'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // Called between edges; returns at a falling edge.
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit inject);
      exp_t        e;
      logic [63:0] p;
      longint      sa, sd, q, r;
      int          k;
      bit          done;
      e.hi = hi_m; e.lo = lo_m; e.n = (op < 3'd2) ? 5 : 10;
      sa = longint'($signed(a));
      sd = longint'($signed(b));
      case (op)
         3'd0: begin q = sa * sd; e.hi = q[63:32]; e.lo = q[31:0]; end
         3'd1: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
         3'd2: if (b != 32'd0) begin
                  q = sa / sd; r = sa % sd; e.hi = r[31:0]; e.lo = q[31:0];
               end
         3'd3: if (b != 32'd0) begin e.lo = a / b; e.hi = a % b; end
         default: ;
      endcase
      if (op < 3'd4) sb_q.push_back(e);
      md_op = op; A = a; B = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (op >= 3'd4) begin
         if (op == 3'd4) hi_m = a;
         if (op == 3'd5) lo_m = a;
         chk("mt_busy", {31'd0, busy}, 32'd0);
         chk("mt_hi", HI, hi_m);
         chk("mt_lo", LO, lo_m);
         @(negedge clk);
      end else begin
         k = 0; done = 1'b0;
         while (!done) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
            else begin
               chk("hold_hi", HI, hi_m);
               chk("hold_lo", LO, lo_m);
               k++;
               if (k > 40) begin
                  total++; bad++;
                  $display("FAIL busy_timeout actual=%0d cycles required=%0d", k, e.n);
                  done = 1'b1;
               end
               if (inject && $urandom_range(0, 2) == 0) begin
                  start = 1'b1; md_op = 3'($urandom_range(0, 7)); A = $urandom; B = $urandom;
               end else start = 1'b0;
            end
         end
         start = 1'b0;
         hi_m = e.hi; lo_m = e.lo;
      end
   endtask

   // Monitor: each falling of busy is one completed operation
   initial begin : monitor
      bit   prev_busy;
      int   run;
      exp_t e;
      prev_busy = 1'b0; run = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_busy = 1'b0; run = 0;
         end else begin
            if (busy) run++;
            else if (prev_busy) begin
               if (sb_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_completion actual=1 required=0");
               end else begin
                  e = sb_q.pop_front();
                  chk("done_hi", HI, e.hi);
                  chk("done_lo", LO, e.lo);
                  chk("busy_len", run, e.n);
               end
               run = 0;
            end
            prev_busy = busy;
         end
      end
   end

   initial begin : driver
      logic [31:0] ra, rb;
      logic [2:0]  rop;
      reset = 1'b1; start = 1'b0; md_op = 3'd0; A = 32'd0; B = 32'd0;
      @(posedge clk); @(posedge clk); #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_hi", HI, 32'd0);
      chk("rst_lo", LO, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      do_op(3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
      chk("mult_hi", HI, 32'hFFFF_FFFF);
      chk("mult_lo", LO, 32'hFFFF_FFF1);
      do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
      chk("div_lo", LO, 32'hFFFF_FFFD);
      chk("div_hi", HI, 32'hFFFF_FFFF);
      do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      do_op(3'd4, 32'h1234_5678, 32'd0, 1'b0);
      do_op(3'd3, 32'd9, 32'd0, 1'b0);
      chk("divu0_hi", HI, 32'h1234_5678);
      chk("divu0_lo", LO, 32'h8000_0000);
      do_op(3'd6, 32'hDEAD_BEEF, 32'd1, 1'b0);
      do_op(3'd7, 32'hCAFE_F00D, 32'd2, 1'b0);
      do_op(3'd1, 32'd7, 32'd6, 1'b1);

      // MULT, ignored MTLO during RUN, then reset mid-RUN
      md_op = 3'd0; A = 32'd3; B = 32'd4; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk);
      md_op = 3'd5; A = 32'hAAAA_0000; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      chk("run_busy", {31'd0, busy}, 32'd1);
      chk("run_mtlo_ignored", LO, lo_m);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      sb_q.delete(); hi_m = 32'd0; lo_m = 32'd0;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_hi", HI, 32'd0);
      chk("midrst_lo", LO, 32'd0);
      @(negedge clk); #1;
      reset = 1'b0;
      do_op(3'd5, 32'h0000_0055, 32'd0, 1'b0);

      repeat (40) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         case ($urandom_range(0, 4))
            0: rb = 32'd0;
            1: rb = 32'hFFFF_FFFF;
            2: rb = 32'($urandom_range(1, 9));
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
         do_op(rop, ra, rb, 1'($urandom_range(0, 1)));
      end

      repeat (3) @(negedge clk);
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
